// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with frame-boundary display updates.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_EN.
module seg_scan_ctrl #(
    parameter int CLK_DIV = 50000,
    parameter int GAP_CYC = 500
) (
    input  logic        hclk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    output logic [7:0]  ans,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int MAX_C = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic {GAP, DRIVE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [31:0]      shown, pend_data;
    logic             pend;
    logic             frame_end;
    logic             xfer;
    logic             blank;
    logic [3:0]       nib;
    logic [7:0]       ans_nxt;
    logic [6:0]       seg_nxt;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge hclk) begin
        if (!rst) begin
            state <= GAP;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        frame_end = 1'b0;
        case (state)
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                end
            end
            DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 3'd1;
                    frame_end = (idx == 3'd7);
                end
            end
            default: state_nxt = GAP;
        endcase
    end

    assign nib      = shown[{idx, 2'b00} +: 4];
    assign xfer     = wr_en && !pend;
    assign wr_ready = !pend;

`ifdef SEG_BLANK_EN
    // Digit 0 is never blanked so an all-zero value still shows a single "0".
    assign blank = (idx != 3'd0) && ((shown >> {idx, 2'b00}) == 32'd0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        ans_nxt = 8'hFF;
        seg_nxt = 7'h7F;
        if (state == DRIVE && !blank) begin
            ans_nxt = ~(8'b1 << idx);
            seg_nxt = font(nib);
        end
    end

    // Outputs lag the scan state by one cycle; shown only changes at frame end,
    // after digit 7's last driven cycle, so no slot ever mixes two values.
    always_ff @(posedge hclk) begin
        if (!rst) begin
            shown      <= '0;
            pend       <= 1'b0;
            ans        <= 8'hFF;
            seg        <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            ans        <= ans_nxt;
            seg        <= seg_nxt;
            frame_done <= frame_end;
            if (frame_end && pend) begin
                shown <= pend_data;
                pend  <= 1'b0;
            end else if (xfer) begin
                pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (xfer) begin
            pend_data <= wr_data;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl with a cycle-position reference model.
module tb_seg_scan_ctrl;

    localparam int CD = 4;
    localparam int GC = 2;
    localparam int P  = CD + GC;
    localparam int FR = 8 * P;

    logic        hclk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [7:0]  ans;
    logic [6:0]  seg;
    logic        frame_done;

    seg_scan_ctrl #(.CLK_DIV(CD), .GAP_CYC(GC)) dut (
        .hclk(hclk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .ans(ans), .seg(seg), .frame_done(frame_done)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;

    logic [6:0] font_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference state: cycles since reset plus the displayed/pending values.
    int          n = 0;
    logic [31:0] m_shown = '0;
    logic [31:0] m_pend_data = '0;
    bit          m_pend = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    function automatic bit blanked(input int dig, input logic [31:0] v);
`ifdef SEG_BLANK_EN
        return (dig != 0) && ((v >> (4 * dig)) == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic step(input logic we, input logic [31:0] d, input logic r);
        logic [7:0] e_ans;
        logic [6:0] e_seg;
        logic       e_fd;
        int         t;
        int         dig;
        bit         fe;
        bit         rdy;
        @(negedge hclk);
        wr_en   = we;
        wr_data = d;
        rst     = r;
        @(posedge hclk);
        e_ans = 8'hFF;
        e_seg = 7'h7F;
        e_fd  = 1'b0;
        if (!r) begin
            n       = 0;
            m_shown = '0;
            m_pend  = 0;
        end else begin
            n++;
            t    = n - 1;
            dig  = (t / P) % 8;
            fe   = (t % FR) == FR - 1;
            e_fd = fe;
            if ((t % P) >= GC && !blanked(dig, m_shown)) begin
                e_ans = ~(8'h01 << dig);
                e_seg = font_tbl[4'((m_shown >> (4 * dig)) & 32'hF)];
            end
            rdy = !m_pend;
            if (fe && m_pend) begin
                m_shown = m_pend_data;
                m_pend  = 0;
            end
            if (we && rdy) begin
                m_pend_data = d;
                m_pend      = 1;
            end
        end
        #1;
        check("ans", 32'(ans), 32'(e_ans));
        check("seg", 32'(seg), 32'(e_seg));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("wr_ready", 32'(wr_ready), 32'(!m_pend));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;

        // Reset then idle through more than one frame.
        do_reset();
        idle(100);

        // Write right after reset; shown from the second frame on.
        do_reset();
        step(1'b1, 32'h89ABCDEF, 1'b1);
        idle(110);

        // Back-to-back writes: second is dropped.
        do_reset();
        step(1'b1, 32'h1, 1'b1);
        step(1'b1, 32'h2, 1'b1);
        idle(110);

        // Write landing in the frame-end cycle with nothing pending.
        do_reset();
        while ((n % FR) != FR - 1) idle(1);
        step(1'b1, 32'h5, 1'b1);
        idle(110);

        // Frame end with pending data while a new write is offered.
        do_reset();
        step(1'b1, 32'h00000A30, 1'b1);
        while ((n % FR) != FR - 1) idle(1);
        step(1'b1, 32'h77777777, 1'b1);
        idle(110);

        // Reset mid-DRIVE with a write pending.
        do_reset();
        step(1'b1, 32'hAAAA5555, 1'b1);
        idle(10);
        step(1'b0, 32'h0, 1'b0);
        idle(60);

        // Randomized writes and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            logic        we;
            logic        r;
            logic [31:0] d;
            we = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 599) != 0);
            d  = ($urandom_range(0, 1) == 0) ? (32'($urandom) >> (4 * $urandom_range(0, 7))) : 32'($urandom);
            step(we, d, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the board's 8-digit common-anode seven-segment display: it shares the single `seg` cathode bus between eight digits by sequencing the `ans` anode enables. It sits inside `top` between the CPU-side display register write and the `seg`/`ans` pins. Display updates are accepted through a valid/ready handshake and applied only at frame boundaries, so a digit never shows half of an old value and half of a new one. A blanking gap between digits suppresses ghosting.

## Interface

Parameters:
- `CLK_DIV`, default 50000: number of `hclk` cycles each digit is driven; legal range is 1 or more.
- `GAP_CYC`, default 500: number of `hclk` cycles all anodes are off between digits; legal range is 1 or more.

Ports:
- `hclk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-low.
- `wr_en`  in  1: write-data valid.
- `wr_data`  in  32: eight hex nibbles; nibble i is bits [4i+3:4i] and goes to digit i.
- `wr_ready`  out  1: controller can accept a write.
- `ans`  out  8: anode enables, active-low, one-hot-low; bit i selects digit i.
- `seg`  out  7: cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `frame_done`  out  1: one-cycle pulse at the end of each full 8-digit frame.

## Operation

- **Registers:**
  - `shown[31:0]`: value currently displayed.
  - `pend_data[31:0]` and `pend`: a single-entry holding buffer.
  - `idx[2:0]`: current digit.
  - `cnt`: slot counter, width `$clog2(max(CLK_DIV,GAP_CYC))`.
  - `state` in {GAP, DRIVE}.
- **GAP state:**
  - `ans`=8'hFF, `seg`=7'h7F.
  - After `GAP_CYC` cycles, move to DRIVE with `cnt` cleared.
- **DRIVE state:**
  - `ans[idx]`=0, all other bits 1.
  - `seg`=font(`shown[4*idx+3:4*idx]`).
  - After `CLK_DIV` cycles, `idx` increments (7 wraps to 0) and the state returns to GAP.
- **Frame end:** the last DRIVE cycle with `idx`=7.
  - `frame_done` pulses for one cycle.
  - If `pend`=1: `shown`<=`pend_data` and `pend`<=0.
- **Font, nibble 0..F:** 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 7-bit).
- **Handshake:**
  - `wr_ready`=!`pend`.
  - A transfer occurs when `wr_en`&&`wr_ready`: `pend_data`<=`wr_data` and `pend`<=1.
  - `wr_en` while `wr_ready`=0 is ignored. The data is dropped and no state changes.
- **Simultaneous events:**
  - A transfer in the frame-end cycle while `pend`=0 loads the buffer only. It is applied at the *next* frame end.
  - A frame end with `pend`=1 and `wr_en`=1 in the same cycle: the buffer drains, and the write is ignored because `wr_ready` was 0 in that cycle.
- **Reset:** when `rst`=0 at an edge, regardless of state, all of the following take effect:
  - state=GAP, `idx`=0, `cnt`=0.
  - `shown`=0, `pend`=0; any pending data is discarded.
  - `ans`=8'hFF, `seg`=7'h7F, `wr_ready`=1, `frame_done`=0.

## Timing

- All outputs are registered and change only on `hclk` edges.
- **Per-digit period:** `GAP_CYC`+`CLK_DIV` cycles. Frame = 8×(`GAP_CYC`+`CLK_DIV`).
- **Start-up:** counting the first edge with `rst`=1 as cycle 1:
  - `ans` stays 8'hFF for cycles 1..`GAP_CYC`.
  - `ans[0]` goes low from cycle `GAP_CYC`+1.
- **Within each DRIVE slot:** `ans` is low for exactly `CLK_DIV` consecutive cycles. `seg` is stable across the whole slot and equals 7'h7F whenever `ans`=8'hFF.
- **`wr_ready` response:**
  - Falls in the cycle after a transfer.
  - Rises in the cycle after the frame end that drains the buffer.
- **Update latency:** a new value appears on digit 0 at the DRIVE slot following the draining frame end. The worst case is about two frames.
- **`frame_done`:** asserted on the edge ending the `idx`=7 DRIVE slot, for one cycle.

## Configuration

- `SEG_BLANK_EN` defined: leading-zero blanking.
  - During the DRIVE slot of any digit i above the most significant nonzero nibble of `shown`, `ans` stays 8'hFF and `seg`=7'h7F.
  - Slot timing and `frame_done` are unchanged.
  - Digit 0 is always driven, so `shown`=0 displays a single "0".
- `SEG_BLANK_EN` undefined: all eight digits are always driven, including leading zeros.

## Test plan

Use `CLK_DIV`=4 and `GAP_CYC`=2 throughout.

- **Reset then idle:**
  - `ans`=FF for cycles 1–2, then `ans`=FE with `seg`=40 for 4 cycles, then FF for 2 cycles, then FD.
  - `frame_done` first pulses at cycle 48.
- **Write 32'h89ABCDEF after reset:**
  - `wr_ready` drops the next cycle and rises after the cycle-48 frame end.
  - The next frame shows digit0 `seg`=0E (F), digit3 46 (C), digit7 00 (8).
- **Back-to-back writes:** 32'h1 then 32'h2 on consecutive cycles. The second is dropped, and 32'h1 is displayed (digit0 `seg`=79).
- **Write in the frame-end cycle:** 32'h5 is written with `pend`=0 in the frame-end cycle. The following frame still shows the old value; the frame after that shows digit0=12.
- **Reset mid-DRIVE with a pending write:** the edge after `rst`=0 gives `ans`=FF, `seg`=7F, `wr_ready`=1, and the pending data is lost (display reverts to 0).
- **`SEG_BLANK_EN`, write 32'h00000A30:**
  - Digits 0–2 are driven: 40, 30, 08.
  - Digits 3–7 keep `ans`=FF during their slots.
  - `frame_done` period is unchanged at 48 cycles.
